nn_scan_controller: RTL and testbench
=====================================

Name: nn_scan_controller

Overview:
Sequences one shared squared-distance unit across a vertex table to find the vertex nearest a query point. Per vertex it reads the position from a BRAM with fixed read latency, issues it with the latched query to the distance unit, and waits for the result. It keeps the running minimum distance and its index. It sits between the graph/vertex memory and the distance datapath, and is started by the search top level.

Parameters:
DIM, 2, number of coordinate dimensions (each 32-bit unsigned)
NUM_VERTICES, 1024, vertex table depth
ADDR_W, $clog2(NUM_VERTICES), vertex address width
MEM_LATENCY, 2, cycles from mem_rd_en_out to valid mem_data_in (>=1)
TIMEOUT, 64, max cycles waited for a distance result

Ports:
clk_in  in  1  system clock
rst_n_in  in  1  asynchronous, active-low reset
start_in  in  1  start pulse; sampled only in IDLE
query_pos_in  in  32 x [DIM-1:0]  query coordinates; latched on accepted start
num_vertices_in  in  ADDR_W+1  vertices to scan (0..NUM_VERTICES); latched on start
mem_addr_out  out  ADDR_W  vertex read address
mem_rd_en_out  out  1  vertex read strobe
mem_data_in  in  32 x [DIM-1:0]  vertex coordinates, valid MEM_LATENCY cycles after strobe
dist_valid_out  out  [DIM-1:0]  per-dimension valid to distance unit (all bits driven identically)
dist_vertex_pos_out  out  32 x [DIM-1:0]  vertex operand
dist_query_pos_out  out  32 x [DIM-1:0]  query operand
dist_sq_in  in  32  squared distance result
dist_valid_in  in  1  result valid, one-cycle pulse
busy_out  out  1  high in every state except IDLE
best_index_out  out  ADDR_W  index of nearest vertex
best_dist_out  out  32  squared distance of nearest vertex
done_out  out  1  one-cycle completion pulse
error_out  out  1  timeout flag; sticky until next accepted start

Behaviour:
- Reset (async, rst_n_in=0): state IDLE. All outputs 0, including best_dist_out, best_index_out, error_out, and all operand buses. Internal counters 0. Any in-flight distance result arriving after reset is ignored.
- States: IDLE, FETCH, WAIT_MEM, ISSUE, WAIT_DIST, DONE.
- IDLE: on start_in, latch query and count; idx=0; best_dist=32'hFFFFFFFF; best_index=0; error=0. If count==0 go to DONE, else go to FETCH. start_in in any other state is ignored.
- FETCH (1 cycle): mem_rd_en_out=1, mem_addr_out=idx. Go to WAIT_MEM with latency counter cleared.
- WAIT_MEM: count cycles. In the cycle exactly MEM_LATENCY after the FETCH cycle, capture mem_data_in into the vertex register and go to ISSUE.
- ISSUE (1 cycle): dist_valid_out all ones. Vertex and query operands are valid here and held stable through WAIT_DIST. Go to WAIT_DIST with timeout counter cleared.
- WAIT_DIST: dist_valid_out=0. On dist_valid_in:
  - if dist_sq_in < best_dist (strict unsigned), update best_dist and best_index=idx. Ties keep the lower index.
  - if idx==count-1, go to DONE; else idx+1 and go to FETCH.
- WAIT_DIST timeout: if TIMEOUT cycles elapse with no result, set error_out=1 and go to DONE. Best values from completed vertices are retained.
- dist_valid_in outside WAIT_DIST is ignored.
- DONE (1 cycle): done_out=1, busy_out still 1. Go to IDLE. best_*_out hold until the next accepted start.
- Throughput: with distance latency L (ISSUE cycle to dist_valid_in cycle), each vertex takes MEM_LATENCY+L+2 cycles. done_out asserts the cycle after the last result.
- mem_rd_en_out and dist_valid_out are never high in the same cycle. There is exactly one outstanding request at a time.
- Index counter must not wrap: count=NUM_VERTICES scans 0..NUM_VERTICES-1 and then stops.

Test Plan:
Bench setup: DIM=2, MEM_LATENCY=2, distance model with L=3.
- Basic: vertices (10,10),(3,4),(7,1), query (0,0), count=3 -> best_index_out=1, best_dist_out=25, done_out 21 cycles after the first FETCH, error_out=0.
- Tie: vertices (3,4),(4,3), query (0,0) -> best_index_out=0, best_dist_out=25.
- Empty: count=0 -> no mem_rd_en_out, done_out the cycle after DONE entry, best_dist_out=32'hFFFFFFFF, best_index_out=0.
- Timeout: model answers vertex 0 (dist 50) and never answers vertex 1, TIMEOUT=64 -> error_out=1 after 64 WAIT_DIST cycles, done pulse, best_dist_out=50, best_index_out=0. A following start clears error_out.
- Reset mid-scan: assert rst_n_in during WAIT_DIST, then deliver a late dist_valid_in -> all outputs 0, state IDLE, late result ignored. A subsequent start scans correctly.
- Start while busy, and query_pos_in changing mid-scan -> no restart; result uses the latched query. Full-depth scan (count=NUM_VERTICES) ends at idx NUM_VERTICES-1 with no address wrap.

Source files
------------

// File: rtl/nn_scan_controller_if.sv
// ---------------------------------------------------------------------------
// nn_scan_controller_if
// Bus bundle between the nearest-neighbour scan controller and its two
// neighbours: the vertex BRAM (read address/strobe, returned coordinates)
// and the shared squared-distance unit (operands/valid out, result in).
//
// Modports
//   master : the scan controller (drives address, strobe, operands)
//   slave  : memory + distance datapath (drives data, result, result valid)
// Signals
//   mem_addr_out        ADDR_W       vertex read address
//   mem_rd_en_out       1            vertex read strobe
//   mem_data_in         DIM x 32     vertex coordinates
//   dist_valid_out      DIM          operand valid, all bits identical
//   dist_vertex_pos_out DIM x 32     vertex operand
//   dist_query_pos_out  DIM x 32     query operand
//   dist_sq_in          32           squared distance result
//   dist_valid_in       1            result valid pulse
// ---------------------------------------------------------------------------
interface nn_scan_controller_if #(
    parameter int DIM    = 2,
    parameter int ADDR_W = 10
);
    logic [ADDR_W-1:0]      mem_addr_out;
    logic                   mem_rd_en_out;
    logic [DIM-1:0][31:0]   mem_data_in;
    logic [DIM-1:0]         dist_valid_out;
    logic [DIM-1:0][31:0]   dist_vertex_pos_out;
    logic [DIM-1:0][31:0]   dist_query_pos_out;
    logic [31:0]            dist_sq_in;
    logic                   dist_valid_in;

    modport master (
        output mem_addr_out,
        output mem_rd_en_out,
        input  mem_data_in,
        output dist_valid_out,
        output dist_vertex_pos_out,
        output dist_query_pos_out,
        input  dist_sq_in,
        input  dist_valid_in
    );

    modport slave (
        input  mem_addr_out,
        input  mem_rd_en_out,
        output mem_data_in,
        input  dist_valid_out,
        input  dist_vertex_pos_out,
        input  dist_query_pos_out,
        output dist_sq_in,
        output dist_valid_in
    );
endinterface

// File: rtl/nn_scan_controller.sv
// ---------------------------------------------------------------------------
// nn_scan_controller
// Walks a vertex table one entry at a time through a single shared
// squared-distance unit and reports the vertex nearest to a latched query.
// Exactly one memory read or distance request is outstanding at any time.
//
// Ports
//   clk_in          system clock
//   rst_n_in        asynchronous active-low reset
//   start_in        start pulse, only honoured while idle
//   query_pos_in    query coordinates, latched on an accepted start
//   num_vertices_in number of vertices to scan (0..NUM_VERTICES), latched
//   bus             memory / distance-unit bundle (master side)
//   busy_out        high in every state except idle
//   best_index_out  index of the nearest vertex found
//   best_dist_out   squared distance of that vertex
//   done_out        one-cycle completion pulse
//   error_out       distance timeout flag, sticky until the next start
// ---------------------------------------------------------------------------
module nn_scan_controller #(
    parameter int DIM          = 2,
    parameter int NUM_VERTICES = 1024,
    parameter int ADDR_W       = $clog2(NUM_VERTICES),
    parameter int MEM_LATENCY  = 2,
    parameter int TIMEOUT      = 64
) (
    input  logic                  clk_in,
    input  logic                  rst_n_in,
    input  logic                  start_in,
    input  logic [DIM-1:0][31:0]  query_pos_in,
    input  logic [ADDR_W:0]       num_vertices_in,
    nn_scan_controller_if.master  bus,
    output logic                  busy_out,
    output logic [ADDR_W-1:0]     best_index_out,
    output logic [31:0]           best_dist_out,
    output logic                  done_out,
    output logic                  error_out
);

    localparam int LAT_W = (MEM_LATENCY > 1) ? $clog2(MEM_LATENCY + 1) : 1;
    localparam int TO_W  = $clog2(TIMEOUT + 1);
    localparam logic [ADDR_W:0]  MAX_COUNT = (ADDR_W+1)'(NUM_VERTICES);
    localparam logic [LAT_W-1:0] LAT_LAST  = LAT_W'(MEM_LATENCY - 1);
    localparam logic [TO_W-1:0]  TO_LAST   = TO_W'(TIMEOUT - 1);

    typedef enum logic [2:0] {
        ST_IDLE      = 3'd0,
        ST_FETCH     = 3'd1,
        ST_WAIT_MEM  = 3'd2,
        ST_ISSUE     = 3'd3,
        ST_WAIT_DIST = 3'd4,
        ST_DONE      = 3'd5
    } state_t;

    state_t                 state_r;
    logic [DIM-1:0][31:0]   query_r;
    logic [DIM-1:0][31:0]   vertex_r;
    logic [ADDR_W:0]        count_r;
    logic [ADDR_W-1:0]      idx_r;
    logic [ADDR_W-1:0]      addr_r;
    logic [LAT_W-1:0]       lat_cnt_r;
    logic [TO_W-1:0]        to_cnt_r;
    logic                   rd_en_r;
    logic [DIM-1:0]         dist_valid_r;
    logic                   busy_r;
    logic [ADDR_W-1:0]      best_idx_r;
    logic [31:0]            best_dist_r;
    logic                   done_r;
    logic                   error_r;

    logic [ADDR_W:0]        count_clamped_s;
    logic                   last_s;

    // Clamp the requested count to the table depth so the index can never run past it.
    always_comb begin
        count_clamped_s = num_vertices_in;
        if (num_vertices_in > MAX_COUNT) begin
            count_clamped_s = MAX_COUNT;
        end else begin
            count_clamped_s = num_vertices_in;
        end
    end

    // True while working on the final vertex; count_r is nonzero whenever this is consulted.
    assign last_s = ({1'b0, idx_r} == (count_r - (ADDR_W+1)'(1)));

    // Scan sequencer: state, counters, operand registers and all registered outputs.
    always_ff @(posedge clk_in or negedge rst_n_in) begin
        if (!rst_n_in) begin
            state_r      <= ST_IDLE;
            query_r      <= '0;
            vertex_r     <= '0;
            count_r      <= '0;
            idx_r        <= '0;
            addr_r       <= '0;
            lat_cnt_r    <= '0;
            to_cnt_r     <= '0;
            rd_en_r      <= 1'b0;
            dist_valid_r <= '0;
            busy_r       <= 1'b0;
            best_idx_r   <= '0;
            best_dist_r  <= 32'd0;
            done_r       <= 1'b0;
            error_r      <= 1'b0;
        end else begin
            // Strobes are single-cycle; each transition below re-asserts the one it needs.
            rd_en_r      <= 1'b0;
            dist_valid_r <= '0;
            done_r       <= 1'b0;
            case (state_r)
                ST_IDLE: begin
                    if (start_in) begin
                        query_r     <= query_pos_in;
                        count_r     <= count_clamped_s;
                        idx_r       <= '0;
                        addr_r      <= '0;
                        best_dist_r <= 32'hFFFF_FFFF;
                        best_idx_r  <= '0;
                        error_r     <= 1'b0;
                        busy_r      <= 1'b1;
                        if (count_clamped_s == '0) begin
                            done_r  <= 1'b1;
                            state_r <= ST_DONE;
                        end else begin
                            rd_en_r <= 1'b1;
                            state_r <= ST_FETCH;
                        end
                    end else begin
                        busy_r <= 1'b0;
                    end
                end
                ST_FETCH: begin
                    lat_cnt_r <= '0;
                    state_r   <= ST_WAIT_MEM;
                end
                ST_WAIT_MEM: begin
                    // lat_cnt_r == k in the (k+1)-th cycle after the read strobe.
                    if (lat_cnt_r == LAT_LAST) begin
                        vertex_r     <= bus.mem_data_in;
                        dist_valid_r <= '1;
                        state_r      <= ST_ISSUE;
                    end else begin
                        lat_cnt_r <= lat_cnt_r + LAT_W'(1);
                    end
                end
                ST_ISSUE: begin
                    to_cnt_r <= '0;
                    state_r  <= ST_WAIT_DIST;
                end
                ST_WAIT_DIST: begin
                    if (bus.dist_valid_in) begin
                        // Strict compare: on a tie the earlier (lower) index is kept.
                        if (bus.dist_sq_in < best_dist_r) begin
                            best_dist_r <= bus.dist_sq_in;
                            best_idx_r  <= idx_r;
                        end else begin
                            best_dist_r <= best_dist_r;
                        end
                        if (last_s) begin
                            done_r  <= 1'b1;
                            state_r <= ST_DONE;
                        end else begin
                            idx_r   <= idx_r + ADDR_W'(1);
                            addr_r  <= idx_r + ADDR_W'(1);
                            rd_en_r <= 1'b1;
                            state_r <= ST_FETCH;
                        end
                    end else if (to_cnt_r == TO_LAST) begin
                        error_r <= 1'b1;
                        done_r  <= 1'b1;
                        state_r <= ST_DONE;
                    end else begin
                        to_cnt_r <= to_cnt_r + TO_W'(1);
                    end
                end
                ST_DONE: begin
                    busy_r  <= 1'b0;
                    state_r <= ST_IDLE;
                end
                default: begin
                    busy_r  <= 1'b0;
                    state_r <= ST_IDLE;
                end
            endcase
        end
    end

    assign bus.mem_addr_out        = addr_r;
    assign bus.mem_rd_en_out       = rd_en_r;
    assign bus.dist_valid_out      = dist_valid_r;
    assign bus.dist_vertex_pos_out = vertex_r;
    assign bus.dist_query_pos_out  = query_r;

    assign busy_out       = busy_r;
    assign best_index_out = best_idx_r;
    assign best_dist_out  = best_dist_r;
    assign done_out       = done_r;
    assign error_out      = error_r;

endmodule

// File: tb/tb_nn_scan_controller.sv
// ---------------------------------------------------------------------------
// tb_nn_scan_controller
// Directed bench for nn_scan_controller: 16-entry vertex BRAM model with
// 2-cycle read latency and a squared-distance model answering 3 cycles
// after the issue cycle. Each scenario task makes its own comparisons.
// ---------------------------------------------------------------------------
`timescale 1ns/1ps
module tb_nn_scan_controller;

    localparam int DIM = 2;
    localparam int NV  = 16;
    localparam int AW  = 4;

    logic                 clk_in = 1'b0;
    logic                 rst_n_in = 1'b0;
    logic                 start_in = 1'b0;
    logic [DIM-1:0][31:0] query_pos_in = '0;
    logic [AW:0]          num_vertices_in = '0;
    logic                 busy_out;
    logic [AW-1:0]        best_index_out;
    logic [31:0]          best_dist_out;
    logic                 done_out;
    logic                 error_out;

    int errors = 0;
    int checks = 0;

    nn_scan_controller_if #(.DIM(DIM), .ADDR_W(AW)) bus_if ();

    nn_scan_controller #(
        .DIM(DIM), .NUM_VERTICES(NV), .ADDR_W(AW), .MEM_LATENCY(2), .TIMEOUT(64)
    ) dut (
        .clk_in(clk_in), .rst_n_in(rst_n_in), .start_in(start_in),
        .query_pos_in(query_pos_in), .num_vertices_in(num_vertices_in),
        .bus(bus_if), .busy_out(busy_out), .best_index_out(best_index_out),
        .best_dist_out(best_dist_out), .done_out(done_out), .error_out(error_out)
    );

    always #5 clk_in = ~clk_in;

    // ---------------- memory and distance models ----------------
    logic [DIM-1:0][31:0] vmem [NV];
    logic [DIM-1:0][31:0] mem_p1 = '0, mem_p2 = '0;
    logic        s1_v = 1'b0, s2_v = 1'b0, s3_v = 1'b0;
    logic [31:0] s1_d = 32'd0, s2_d = 32'd0, s3_d = 32'd0;
    int          issue_cnt = 0;
    int          answer_limit = 32'h7FFF_FFFF;
    int          cyc = 0, rd_count = 0, last_addr = 0, overlap_cnt = 0, late_cnt = 0;

    function automatic logic [31:0] sqd(input logic [31:0] a, input logic [31:0] b);
        logic [31:0] d;
        d = (a > b) ? (a - b) : (b - a);
        return d * d;
    endfunction

    always @(posedge clk_in) begin
        mem_p1 <= bus_if.mem_rd_en_out ? vmem[bus_if.mem_addr_out] : 64'd0;
        mem_p2 <= mem_p1;
        s1_v <= bus_if.dist_valid_out[0] && (issue_cnt < answer_limit);
        s1_d <= sqd(bus_if.dist_vertex_pos_out[0], bus_if.dist_query_pos_out[0]) +
                sqd(bus_if.dist_vertex_pos_out[1], bus_if.dist_query_pos_out[1]);
        if (bus_if.dist_valid_out[0]) issue_cnt <= issue_cnt + 1;
        s2_v <= s1_v; s2_d <= s1_d;
        s3_v <= s2_v; s3_d <= s2_d;
    end

    assign bus_if.mem_data_in   = mem_p2;
    assign bus_if.dist_sq_in    = s3_d;
    assign bus_if.dist_valid_in = s3_v;

    // Bus monitor counters used by the scenario tasks.
    always @(posedge clk_in) begin
        cyc <= cyc + 1;
        if (bus_if.mem_rd_en_out) begin
            rd_count  <= rd_count + 1;
            last_addr <= int'(bus_if.mem_addr_out);
        end
        if ((bus_if.mem_rd_en_out && (bus_if.dist_valid_out != 2'b00)) ||
            (bus_if.dist_valid_out != 2'b00 && bus_if.dist_valid_out != 2'b11))
            overlap_cnt <= overlap_cnt + 1;
        if (s3_v && !busy_out) late_cnt <= late_cnt + 1;
    end

    // ---------------- helpers ----------------
    task automatic set_vertex(input int i, input int x, input int y);
        vmem[i][0] = 32'(x);
        vmem[i][1] = 32'(y);
    endtask

    // Returns at the negedge after the start was sampled (first FETCH cycle).
    task automatic start_scan(input int cnt, input int qx, input int qy);
        @(negedge clk_in);
        start_in = 1'b1;
        num_vertices_in = (AW+1)'(cnt);
        query_pos_in[0] = 32'(qx);
        query_pos_in[1] = 32'(qy);
        @(negedge clk_in);
        start_in = 1'b0;
    endtask

    task automatic wait_done(output bit ok);
        ok = 1'b0;
        for (int i = 0; i < 400; i++) begin
            if (done_out) begin
                ok = 1'b1;
                break;
            end
            @(negedge clk_in);
        end
        if (!ok) $display("FAIL wait_done: done_out never asserted within 400 cycles");
    endtask

    // ---------------- scenarios ----------------
    task automatic test_reset;
        #1;
        checks++; if (busy_out !== 1'b0) begin errors++; $display("FAIL reset_busy: got %b expected 0", busy_out); end
        checks++; if (best_dist_out !== 32'd0) begin errors++; $display("FAIL reset_best_dist: got %h expected 0", best_dist_out); end
        checks++; if (best_index_out !== 4'd0 || done_out !== 1'b0 || error_out !== 1'b0) begin errors++; $display("FAIL reset_status: idx=%0d done=%b err=%b expected 0/0/0", best_index_out, done_out, error_out); end
        checks++; if (bus_if.mem_rd_en_out !== 1'b0 || bus_if.dist_valid_out !== 2'b00 || bus_if.mem_addr_out !== 4'd0) begin errors++; $display("FAIL reset_bus: rd=%b dv=%b addr=%0d expected 0", bus_if.mem_rd_en_out, bus_if.dist_valid_out, bus_if.mem_addr_out); end
        checks++; if (bus_if.dist_vertex_pos_out !== 64'd0 || bus_if.dist_query_pos_out !== 64'd0) begin errors++; $display("FAIL reset_operands: v=%h q=%h expected 0", bus_if.dist_vertex_pos_out, bus_if.dist_query_pos_out); end
    endtask

    task automatic test_basic;
        int c0, r0; bit ok;
        set_vertex(0, 10, 10); set_vertex(1, 3, 4); set_vertex(2, 7, 1);
        r0 = rd_count;
        start_scan(3, 0, 0);
        c0 = cyc;
        checks++; if (busy_out !== 1'b1 || bus_if.mem_rd_en_out !== 1'b1) begin errors++; $display("FAIL basic_fetch: busy=%b rd=%b expected 1/1", busy_out, bus_if.mem_rd_en_out); end
        wait_done(ok);
        checks++; if (!ok || (cyc - c0) != 21) begin errors++; $display("FAIL basic_latency: got %0d cycles expected 21", cyc - c0); end
        checks++; if (best_index_out !== 4'd1) begin errors++; $display("FAIL basic_index: got %0d expected 1", best_index_out); end
        checks++; if (best_dist_out !== 32'd25) begin errors++; $display("FAIL basic_dist: got %0d expected 25", best_dist_out); end
        checks++; if (error_out !== 1'b0 || busy_out !== 1'b1) begin errors++; $display("FAIL basic_done_status: err=%b busy=%b expected 0/1", error_out, busy_out); end
        checks++; if (rd_count - r0 != 3) begin errors++; $display("FAIL basic_reads: got %0d expected 3", rd_count - r0); end
        @(negedge clk_in);
        checks++; if (done_out !== 1'b0 || busy_out !== 1'b0 || best_dist_out !== 32'd25) begin errors++; $display("FAIL basic_after: done=%b busy=%b dist=%0d expected 0/0/25", done_out, busy_out, best_dist_out); end
    endtask

    task automatic test_tie;
        bit ok;
        set_vertex(0, 3, 4); set_vertex(1, 4, 3);
        start_scan(2, 0, 0);
        wait_done(ok);
        checks++; if (best_index_out !== 4'd0 || best_dist_out !== 32'd25) begin errors++; $display("FAIL tie: idx=%0d dist=%0d expected 0/25", best_index_out, best_dist_out); end
    endtask

    task automatic test_empty;
        int r0;
        r0 = rd_count;
        start_scan(0, 5, 5);
        checks++; if (done_out !== 1'b1 || busy_out !== 1'b1) begin errors++; $display("FAIL empty_done: done=%b busy=%b expected 1/1", done_out, busy_out); end
        checks++; if (best_dist_out !== 32'hFFFF_FFFF || best_index_out !== 4'd0) begin errors++; $display("FAIL empty_best: dist=%h idx=%0d expected ffffffff/0", best_dist_out, best_index_out); end
        repeat (3) @(negedge clk_in);
        checks++; if (rd_count != r0 || busy_out !== 1'b0) begin errors++; $display("FAIL empty_reads: reads=%0d busy=%b expected 0/0", rd_count - r0, busy_out); end
    endtask

    task automatic test_timeout;
        int c0; bit ok;
        set_vertex(0, 5, 5); set_vertex(1, 1, 1);
        answer_limit = issue_cnt + 1;
        start_scan(2, 0, 0);
        c0 = cyc;
        wait_done(ok);
        checks++; if (!ok || (cyc - c0) != 75) begin errors++; $display("FAIL timeout_latency: got %0d cycles expected 75", cyc - c0); end
        checks++; if (error_out !== 1'b1) begin errors++; $display("FAIL timeout_error: got %b expected 1", error_out); end
        checks++; if (best_dist_out !== 32'd50 || best_index_out !== 4'd0) begin errors++; $display("FAIL timeout_best: dist=%0d idx=%0d expected 50/0", best_dist_out, best_index_out); end
        answer_limit = 32'h7FFF_FFFF;
        repeat (4) @(negedge clk_in);
        checks++; if (error_out !== 1'b1 || busy_out !== 1'b0) begin errors++; $display("FAIL timeout_sticky: err=%b busy=%b expected 1/0", error_out, busy_out); end
        set_vertex(0, 10, 10); set_vertex(1, 3, 4); set_vertex(2, 7, 1);
        start_scan(3, 0, 0);
        checks++; if (error_out !== 1'b0) begin errors++; $display("FAIL timeout_clear: got %b expected 0", error_out); end
        wait_done(ok);
        checks++; if (best_index_out !== 4'd1 || best_dist_out !== 32'd25 || error_out !== 1'b0) begin errors++; $display("FAIL timeout_rescan: idx=%0d dist=%0d err=%b expected 1/25/0", best_index_out, best_dist_out, error_out); end
    endtask

    task automatic test_reset_mid_scan;
        int l0; bit found, ok;
        set_vertex(0, 10, 10); set_vertex(1, 3, 4); set_vertex(2, 7, 1);
        start_scan(3, 0, 0);
        found = 1'b0;
        for (int i = 0; i < 20; i++) begin
            if (bus_if.dist_valid_out == 2'b11) begin found = 1'b1; break; end
            @(negedge clk_in);
        end
        checks++; if (!found) begin errors++; $display("FAIL rst_find_issue: no issue within 20 cycles"); end
        l0 = late_cnt;
        @(negedge clk_in);
        rst_n_in = 1'b0;
        #1;
        checks++; if (busy_out !== 1'b0 || best_dist_out !== 32'd0 || bus_if.dist_query_pos_out !== 64'd0) begin errors++; $display("FAIL rst_async: busy=%b dist=%h q=%h expected 0", busy_out, best_dist_out, bus_if.dist_query_pos_out); end
        @(negedge clk_in);
        rst_n_in = 1'b1;
        repeat (3) @(negedge clk_in);
        checks++; if (late_cnt - l0 != 1) begin errors++; $display("FAIL rst_late_delivered: got %0d late results expected 1", late_cnt - l0); end
        checks++; if (busy_out !== 1'b0 || done_out !== 1'b0 || best_dist_out !== 32'd0 || best_index_out !== 4'd0 || error_out !== 1'b0) begin errors++; $display("FAIL rst_ignore_late: busy=%b done=%b dist=%0d idx=%0d err=%b expected all 0", busy_out, done_out, best_dist_out, best_index_out, error_out); end
        start_scan(3, 0, 0);
        wait_done(ok);
        checks++; if (best_index_out !== 4'd1 || best_dist_out !== 32'd25) begin errors++; $display("FAIL rst_rescan: idx=%0d dist=%0d expected 1/25", best_index_out, best_dist_out); end
    endtask

    task automatic test_busy_restart;
        int c0; bit ok;
        set_vertex(0, 10, 10); set_vertex(1, 3, 4); set_vertex(2, 7, 1);
        start_scan(3, 0, 0);
        c0 = cyc;
        repeat (3) @(negedge clk_in);
        start_in = 1'b1;
        num_vertices_in = 5'd1;
        query_pos_in[0] = 32'd10;
        query_pos_in[1] = 32'd10;
        @(negedge clk_in);
        start_in = 1'b0;
        wait_done(ok);
        checks++; if (!ok || (cyc - c0) != 21) begin errors++; $display("FAIL busy_no_restart: got %0d cycles expected 21", cyc - c0); end
        checks++; if (best_index_out !== 4'd1 || best_dist_out !== 32'd25) begin errors++; $display("FAIL busy_latched_query: idx=%0d dist=%0d expected 1/25", best_index_out, best_dist_out); end
    endtask

    task automatic test_full_depth;
        int c0, r0; bit ok;
        for (int i = 0; i < NV; i++) set_vertex(i, 20 - i, 0);
        r0 = rd_count;
        start_scan(NV, 0, 0);
        c0 = cyc;
        wait_done(ok);
        checks++; if (!ok || (cyc - c0) != 112) begin errors++; $display("FAIL full_latency: got %0d cycles expected 112", cyc - c0); end
        checks++; if (best_index_out !== 4'd15 || best_dist_out !== 32'd25) begin errors++; $display("FAIL full_best: idx=%0d dist=%0d expected 15/25", best_index_out, best_dist_out); end
        repeat (10) @(negedge clk_in);
        checks++; if (rd_count - r0 != NV || last_addr != NV - 1) begin errors++; $display("FAIL full_reads: reads=%0d last=%0d expected 16/15", rd_count - r0, last_addr); end
        checks++; if (busy_out !== 1'b0) begin errors++; $display("FAIL full_idle: busy=%b expected 0", busy_out); end
    endtask

    task automatic test_bus_exclusive;
        checks++; if (overlap_cnt != 0) begin errors++; $display("FAIL bus_exclusive: got %0d bad cycles expected 0", overlap_cnt); end
    endtask

    initial begin
        for (int i = 0; i < NV; i++) vmem[i] = '0;
        repeat (3) @(negedge clk_in);
        test_reset();
        rst_n_in = 1'b1;
        @(negedge clk_in);
        test_basic();
        test_tie();
        test_empty();
        test_timeout();
        test_reset_mid_scan();
        test_busy_restart();
        test_full_depth();
        test_bus_exclusive();
        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
